fetch_stage: RTL and testbench



---
 rtl/riscv_pkg.sv | 16 +
 rtl/pc_reg.sv | 36 +++
 rtl/fetch_stage.sv | 143 ++++++++++++++
 tb/tb_fetch_stage.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I core: datapath width, reset vector and
// the fetch-stage state encoding.
package riscv_pkg;

    localparam int DATA_WIDTH = 32;
    localparam logic [DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program-counter register: reset value, absolute load, and +INSTR_BYTES
// increment (modulo 2^W). Load wins over increment.
module pc_reg
    import riscv_pkg::*;
#(
    parameter int          W         = 32,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] pc_q
);

    logic [W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_val;
        end else if (inc) begin
            pc_d = pc_q + W'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_VAL;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request in
// flight, buffers a word while IF/ID stalls and discards fetches made stale by a redirect.
module fetch_stage #(
    parameter int                    DATA_WIDTH = riscv_pkg::DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = riscv_pkg::RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_f,
    input  logic                   pc_src_e,
    input  logic [DATA_WIDTH-1:0]  pc_target_e,
    output logic                   imem_req,
    output logic [DATA_WIDTH-1:0]  imem_addr,
    input  logic                   imem_rvalid,
    input  logic [DATA_WIDTH-1:0]  imem_rdata,
    output logic                   valid_f,
    output logic [DATA_WIDTH-1:0]  instr_f,
    output logic [DATA_WIDTH-1:0]  pc_f,
    output logic [DATA_WIDTH-1:0]  pc_plus4_f,
    output riscv_pkg::fetch_state_t state_dbg
);

    import riscv_pkg::*;

    // Handshake: imem_req is a one-cycle pulse with imem_addr valid alongside;
    // the memory answers each request with exactly one imem_rvalid pulse,
    // no earlier than the following cycle. valid_f marks a word for IF/ID,
    // consumed only in a cycle with stall_f=0 and pc_src_e=0.

    fetch_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_req_q, pc_req_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  issue;
    logic                  present;
    logic                  capture;
    logic [DATA_WIDTH-1:0] instr_sel;

    assign redirect_pc = {pc_target_e[DATA_WIDTH-1:2], 2'b00};

    pc_reg #(
        .W         (DATA_WIDTH),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_src_e),
        .load_val (redirect_pc),
        .inc      (issue),
        .pc_q     (pc_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_req_q <= RESET_PC;
            buf_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_req_q <= pc_req_d;
            buf_q    <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                state_d = pc_src_e ? IDLE : WAIT;
            end
            WAIT: begin
                if (pc_src_e) begin
                    state_d = imem_rvalid ? IDLE : DROP;
                end else if (imem_rvalid) begin
                    state_d = stall_f ? HOLD : WAIT;
                end
            end
            HOLD: begin
                if (pc_src_e) begin
                    state_d = IDLE;
                end else if (!stall_f) begin
                    state_d = WAIT;
                end
            end
            DROP: begin
                // A redirect here only moves the PC; the stale response still has to land.
                if (imem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue     = 1'b0;
        present   = 1'b0;
        capture   = 1'b0;
        instr_sel = '0;
        unique case (state_q)
            IDLE: begin
                issue = !pc_src_e;
            end
            WAIT: begin
                if (imem_rvalid && !pc_src_e) begin
                    present   = 1'b1;
                    instr_sel = imem_rdata;
                    issue     = !stall_f;
                    capture   = stall_f;
                end
            end
            HOLD: begin
                if (!pc_src_e) begin
                    present   = 1'b1;
                    instr_sel = buf_q;
                    issue     = !stall_f;
                end
            end
            default: ;
        endcase
        if (rst) begin
            issue     = 1'b0;
            present   = 1'b0;
            capture   = 1'b0;
            instr_sel = '0;
        end
    end

    always_comb begin
        pc_req_d = issue   ? pc_q       : pc_req_q;
        buf_d    = capture ? imem_rdata : buf_q;
    end

    assign imem_req   = issue;
    assign imem_addr  = pc_q;
    assign valid_f    = present;
    assign instr_f    = instr_sel;
    assign pc_f       = pc_req_q;
    assign pc_plus4_f = pc_req_q + DATA_WIDTH'(INSTR_BYTES);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a directed per-cycle vector table, multi-cycle
// sequences, and a randomized run against a program-order stream model.
module tb_fetch_stage;

    import riscv_pkg::*;

    localparam int W = 32;
    localparam logic [W-1:0] WRAP_PC = 32'hFFFF_FFFC;

    logic         clk = 1'b0;
    logic         rst;
    logic         stall_f;
    logic         pc_src_e;
    logic [W-1:0] pc_target_e;
    logic         imem_rvalid;
    logic [W-1:0] imem_rdata;

    logic         imem_req, valid_f;
    logic [W-1:0] imem_addr, instr_f, pc_f, pc_plus4_f;
    fetch_state_t state_dbg;

    logic         imem_req1, valid_f1;
    logic [W-1:0] imem_addr1, instr_f1, pc_f1, pc_plus4_f1;
    fetch_state_t state_dbg1;

    int checks = 0;
    int errors = 0;

    int           mem_lat = 1;
    logic         mem_rand_lat = 1'b0;
    logic         mem_busy;
    int           mem_cnt;
    logic [W-1:0] mem_pend;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic         stall;
        logic         redir;
        logic [W-1:0] tgt;
        logic         req;
        logic [W-1:0] addr;
        logic         valid;
        logic [W-1:0] pc;
        logic [W-1:0] pc1;
        logic [W-1:0] addr1;
    } vec_t;

    vec_t tv[13];

    always #5 clk = ~clk;

    fetch_stage u_dut (
        .clk         (clk),
        .rst         (rst),
        .stall_f     (stall_f),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .valid_f     (valid_f),
        .instr_f     (instr_f),
        .pc_f        (pc_f),
        .pc_plus4_f  (pc_plus4_f),
        .state_dbg   (state_dbg)
    );

    // Same inputs as u_dut, so it runs in lockstep; only its PC values differ.
    fetch_stage #(.RESET_PC(WRAP_PC)) u_dut_wrap (
        .clk         (clk),
        .rst         (rst),
        .stall_f     (stall_f),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .imem_req    (imem_req1),
        .imem_addr   (imem_addr1),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .valid_f     (valid_f1),
        .instr_f     (instr_f1),
        .pc_f        (pc_f1),
        .pc_plus4_f  (pc_plus4_f1),
        .state_dbg   (state_dbg1)
    );

    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        if (a == '0) return 32'h0050_0093;
        return {a[W-1:2], 2'b11} ^ 32'h5A00_0010;
    endfunction

    function automatic vec_t mk(input logic s, input logic r, input logic [W-1:0] t,
                                input logic q, input logic [W-1:0] a, input logic v,
                                input logic [W-1:0] p, input logic [W-1:0] p1,
                                input logic [W-1:0] a1);
        vec_t x;
        x.stall = s; x.redir = r; x.tgt = t; x.req = q; x.addr = a;
        x.valid = v; x.pc = p; x.pc1 = p1; x.addr1 = a1;
        return x;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; stall_f = 1'b0; pc_src_e = 1'b0; pc_target_e = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Memory: latency counted from the request cycle; reset together with the core.
    logic         m_req_c, m_rst_c;
    logic [W-1:0] m_addr_c;
    initial begin
        imem_rvalid = 1'b0; imem_rdata = '0;
        mem_busy = 1'b0; mem_cnt = 0; mem_pend = '0;
        forever begin
            @(negedge clk);
            m_req_c = imem_req; m_addr_c = imem_addr; m_rst_c = rst;
            if (m_req_c) check1("one_outstanding", mem_busy, 1'b0);
            @(posedge clk); #1;
            imem_rvalid = 1'b0;
            if (m_rst_c) begin
                mem_busy = 1'b0;
            end else begin
                if (m_req_c) begin
                    mem_busy = 1'b1;
                    mem_pend = m_addr_c;
                    mem_cnt  = mem_rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
                end
                if (mem_busy) begin
                    mem_cnt--;
                    if (mem_cnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = mem_word(mem_pend);
                        mem_busy    = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : main
        logic         found, dropped;
        int           vcount;
        logic [W-1:0] exp_pc, e;
        logic         held;
        int           consumed;

        rst = 1'b1; stall_f = 1'b0; pc_src_e = 1'b0; pc_target_e = '0;

        tv[0]  = mk(0, 0, 0,        1, 32'h0,   0, 32'h0,   WRAP_PC, WRAP_PC);
        tv[1]  = mk(0, 0, 0,        1, 32'h4,   1, 32'h0,   WRAP_PC, 32'h0);
        tv[2]  = mk(1, 0, 0,        0, 32'h0,   1, 32'h4,   32'h0,   32'h0);
        tv[3]  = mk(1, 0, 0,        0, 32'h0,   1, 32'h4,   32'h0,   32'h0);
        tv[4]  = mk(1, 0, 0,        0, 32'h0,   1, 32'h4,   32'h0,   32'h0);
        tv[5]  = mk(0, 0, 0,        1, 32'h8,   1, 32'h4,   32'h0,   32'h4);
        tv[6]  = mk(0, 1, 32'h103,  0, 32'h0,   0, 32'h8,   32'h4,   32'h0);
        tv[7]  = mk(0, 0, 0,        1, 32'h100, 0, 32'h8,   32'h4,   32'h100);
        tv[8]  = mk(1, 0, 0,        0, 32'h0,   1, 32'h100, 32'h100, 32'h0);
        tv[9]  = mk(1, 1, 32'h200,  0, 32'h0,   0, 32'h100, 32'h100, 32'h0);
        tv[10] = mk(0, 0, 0,        1, 32'h200, 0, 32'h100, 32'h100, 32'h200);
        tv[11] = mk(0, 0, 0,        1, 32'h204, 1, 32'h200, 32'h200, 32'h204);
        tv[12] = mk(0, 0, 0,        1, 32'h208, 1, 32'h204, 32'h204, 32'h208);

        // Reset values
        @(posedge clk);
        @(negedge clk);
        check1("rst_req", imem_req, 1'b0);
        check1("rst_valid", valid_f, 1'b0);
        check("rst_instr", instr_f, '0);
        check("rst_pc", pc_f, 32'h0);
        check("rst_pc4", pc_plus4_f, 32'h4);
        check1("rst_state", state_dbg == IDLE, 1'b1);
        check("rst_pc_wrap", pc_f1, WRAP_PC);
        check("rst_pc4_wrap", pc_plus4_f1, 32'h0);
        check("rst_instr_wrap", instr_f1, '0);
        check1("rst_state_wrap", state_dbg1 == IDLE, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed table, 1-cycle memory
        for (int i = 0; i < 13; i++) begin
            stall_f = tv[i].stall; pc_src_e = tv[i].redir; pc_target_e = tv[i].tgt;
            @(negedge clk);
            check1($sformatf("v%0d_req", i), imem_req, tv[i].req);
            if (tv[i].req) check($sformatf("v%0d_addr", i), imem_addr, tv[i].addr);
            check1($sformatf("v%0d_valid", i), valid_f, tv[i].valid);
            check($sformatf("v%0d_pc", i), pc_f, tv[i].pc);
            check($sformatf("v%0d_pc4", i), pc_plus4_f, tv[i].pc + 32'd4);
            if (tv[i].valid) check($sformatf("v%0d_instr", i), instr_f, mem_word(tv[i].pc));
            check($sformatf("v%0d_pc_wrap", i), pc_f1, tv[i].pc1);
            if (tv[i].req) check($sformatf("v%0d_addr_wrap", i), imem_addr1, tv[i].addr1);
            @(posedge clk); #1;
        end
        stall_f = 1'b0; pc_src_e = 1'b0; pc_target_e = '0;

        // 3-cycle latency: four fetches in order within 14 cycles
        mem_lat = 3;
        do_reset();
        exp_q = {32'h0, 32'h4, 32'h8, 32'hC};
        vcount = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (valid_f) begin
                vcount++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                check("lat3_pc", pc_f, e);
                check("lat3_instr", instr_f, mem_word(e));
            end
            @(posedge clk); #1;
        end
        check("lat3_valid_count", W'(vcount), 32'd4);

        // Redirect to 0x103 while the fetch of 0x8 is in flight
        do_reset();
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge clk);
            found = imem_req && (imem_addr == 32'h8);
            @(posedge clk); #1;
        end
        if (!found) timeout("drop_wait_req8");
        pc_src_e = 1'b1; pc_target_e = 32'h103;
        @(negedge clk);
        check1("drop_redir_valid", valid_f, 1'b0);
        check1("drop_redir_req", imem_req, 1'b0);
        @(posedge clk); #1;
        pc_src_e = 1'b0; pc_target_e = '0;
        found = 1'b0; dropped = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            check1("drop_no_valid", valid_f, 1'b0);
            if (imem_rvalid) dropped = 1'b1;
            if (imem_req) begin
                found = 1'b1;
                check("drop_next_addr", imem_addr, 32'h100);
            end
            @(posedge clk); #1;
        end
        if (!found) timeout("drop_wait_req100");
        check1("drop_resp_seen", dropped, 1'b1);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (valid_f) begin
                found = 1'b1;
                check("drop_first_pc", pc_f, 32'h100);
                check("drop_first_instr", instr_f, mem_word(32'h100));
            end
            @(posedge clk); #1;
        end
        if (!found) timeout("drop_wait_valid");

        // Reset asserted while a request is outstanding
        do_reset();
        @(negedge clk);
        check1("rstw_req0", imem_req1, 1'b1);
        check("rstw_addr0", imem_addr1, WRAP_PC);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check1("rstw_req", imem_req1, 1'b0);
        check1("rstw_valid", valid_f1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstw_pc", pc_f1, WRAP_PC);
        check("rstw_pc0", pc_f, 32'h0);
        check1("rstw_valid_after", valid_f1, 1'b0);
        check1("rstw_reissue", imem_req1, 1'b1);
        check("rstw_reissue_addr", imem_addr1, WRAP_PC);
        @(posedge clk); #1;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (valid_f1) begin
                found = 1'b1;
                check("rstw_first_pc", pc_f1, WRAP_PC);
            end
            @(posedge clk); #1;
        end
        if (!found) timeout("rstw_wait_valid");

        // Random stall/redirect/latency against the program-order stream
        mem_rand_lat = 1'b1;
        do_reset();
        exp_pc = RESET_PC; held = 1'b0; consumed = 0;
        for (int n = 0; n < 3000; n++) begin
            stall_f     = ($urandom_range(0, 99) < 30);
            pc_src_e    = ($urandom_range(0, 99) < 6);
            pc_target_e = $urandom;
            @(negedge clk);
            if (pc_src_e) begin
                check1("rnd_redir_valid", valid_f, 1'b0);
                exp_pc = {pc_target_e[W-1:2], 2'b00};
                held = 1'b0;
            end else begin
                if (held) check1("rnd_hold_valid", valid_f, 1'b1);
                if (valid_f) begin
                    check("rnd_pc", pc_f, exp_pc);
                    check("rnd_instr", instr_f, mem_word(exp_pc));
                    check("rnd_pc4", pc_plus4_f, exp_pc + 32'd4);
                    if (!stall_f) begin
                        exp_pc = exp_pc + 32'd4;
                        consumed++;
                        held = 1'b0;
                    end else begin
                        held = 1'b1;
                    end
                end else begin
                    held = 1'b0;
                end
            end
            @(posedge clk); #1;
        end
        check1("rnd_progress", consumed > 100, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
